// File: rtl/node_nic.sv
// node_nic: node-side network interface for one router port.
//   TX: 32-bit packets from the node are queued, then sent MSB byte first
//       as 4 back-to-back put cycles once the router reports free.
//   RX: the router byte stream is reassembled into 32-bit packets and
//       queued for the node. Misrouted packets are flagged. Packets that
//       arrive while the queue is full are dropped and flagged.
// Ports:
//   clk, rst_b                         clock, async active-low reset
//   pkt_in, pkt_in_valid, pkt_in_ready node -> TX queue
//   free_to_router, put_to_router,
//   payload_to_router                  TX byte interface to router
//   put_from_router, payload_from_router,
//   free_from_node                     RX byte interface from router
//   pkt_out, pkt_out_valid, pkt_out_ready  RX queue -> node
//   misroute, rx_overflow              sticky status flags
//
// TX FSM states:
//   state | meaning
//   IDLE  | nothing on the router link, waiting for queued packet + free
//   SEND  | driving byte tx_idx of the current packet (put_to_router=1)
module node_nic #(
   parameter int NODEID   = 0,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [31:0] pkt_in,
   input  logic        pkt_in_valid,
   output logic        pkt_in_ready,
   input  logic        free_to_router,
   output logic        put_to_router,
   output logic [7:0]  payload_to_router,
   input  logic        put_from_router,
   input  logic [7:0]  payload_from_router,
   output logic        free_from_node,
   output logic [31:0] pkt_out,
   output logic        pkt_out_valid,
   input  logic        pkt_out_ready,
   output logic        misroute,
   output logic        rx_overflow
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

   typedef enum logic {IDLE, SEND} tx_state_t;

   // ---------------- TX queue ----------------
   logic [31:0]  tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wr, tx_rd;
   logic         tx_empty, tx_full, tx_push, tx_start;
   logic [31:0]  tx_head;

   tx_state_t    tx_state;
   logic [1:0]   tx_idx;
   logic [23:0]  tx_sh;

   assign tx_empty     = (tx_wr == tx_rd);
   assign tx_full      = (tx_wr[TAW] != tx_rd[TAW]) && (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]);
   assign pkt_in_ready = ~tx_full;
   assign tx_push      = pkt_in_valid & ~tx_full;
   assign tx_head      = tx_mem[tx_rd[TAW-1:0]];

   // A new packet may start from IDLE or on the edge ending byte 3 of the
   // current one, which gives back-to-back packets with no idle gap.
   assign tx_start = ~tx_empty & free_to_router &
                     ((tx_state == IDLE) || (tx_idx == 2'd3));

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr[TAW-1:0]] <= pkt_in;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         tx_state          <= IDLE;
         tx_idx            <= 2'd0;
         tx_sh             <= 24'd0;
         tx_wr             <= '0;
         tx_rd             <= '0;
         put_to_router     <= 1'b0;
         payload_to_router <= 8'd0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_start) begin
            tx_rd             <= tx_rd + 1'b1;
            tx_state          <= SEND;
            tx_idx            <= 2'd0;
            tx_sh             <= tx_head[23:0];
            put_to_router     <= 1'b1;
            payload_to_router <= tx_head[31:24];
         end else begin
            case (tx_state)
               IDLE: begin
                  put_to_router     <= 1'b0;
                  payload_to_router <= 8'd0;
               end
               SEND: begin
                  if (tx_idx == 2'd3) begin
                     tx_state          <= IDLE;
                     put_to_router     <= 1'b0;
                     payload_to_router <= 8'd0;
                  end else begin
                     tx_idx            <= tx_idx + 2'd1;
                     payload_to_router <= tx_sh[23:16];
                     tx_sh             <= {tx_sh[15:0], 8'd0};
                  end
               end
               default: tx_state <= IDLE;
            endcase
         end
      end
   end

   // ---------------- RX assembler and queue ----------------
   logic [31:0]    rx_mem [RX_DEPTH];
   logic [RAW-1:0] rx_wr, rx_rd;
   logic [RAW:0]   rx_count;
   logic [1:0]     rx_cnt;
   logic [23:0]    rx_sh;
   logic [31:0]    rx_pkt;
   logic           rx_done, rx_full, rx_pop, rx_push;
   logic [RAW+1:0] rx_need;

   assign rx_done       = put_from_router & (rx_cnt == 2'd3);
   assign rx_pkt        = {rx_sh, payload_from_router};
   assign rx_full       = (rx_count == (RAW+1)'(RX_DEPTH));
   assign pkt_out_valid = (rx_count != '0);
   assign rx_pop        = pkt_out_valid & pkt_out_ready;
   // A pop in the same cycle frees the slot, so a full queue can still accept.
   assign rx_push       = rx_done & (~rx_full | rx_pop);
   assign pkt_out       = pkt_out_valid ? rx_mem[rx_rd] : 32'd0;

   // A partially received packet already claims a slot.
   assign rx_need        = {1'b0, rx_count} + (RAW+2)'(rx_cnt != 2'd0);
   assign free_from_node = (rx_need < (RAW+2)'(RX_DEPTH));

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr] <= rx_pkt;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rx_cnt      <= 2'd0;
         rx_sh       <= 24'd0;
         rx_wr       <= '0;
         rx_rd       <= '0;
         rx_count    <= '0;
         misroute    <= 1'b0;
         rx_overflow <= 1'b0;
      end else begin
         if (put_from_router) begin
            rx_cnt <= rx_cnt + 2'd1;
            rx_sh  <= {rx_sh[15:0], payload_from_router};
         end
         if (rx_done && (rx_pkt[27:24] != 4'(NODEID))) misroute <= 1'b1;
         if (rx_done && !rx_push) rx_overflow <= 1'b1;
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)  rx_rd <= rx_rd + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

endmodule

// File: tb/tb_node_nic.sv
// tb_node_nic: directed bench for node_nic (NODEID=3, TX_DEPTH=4, RX_DEPTH=2).
module tb_node_nic;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] pkt_in;
   logic        pkt_in_valid;
   logic        pkt_in_ready;
   logic        free_to_router;
   logic        put_to_router;
   logic [7:0]  payload_to_router;
   logic        put_from_router;
   logic [7:0]  payload_from_router;
   logic        free_from_node;
   logic [31:0] pkt_out;
   logic        pkt_out_valid;
   logic        pkt_out_ready;
   logic        misroute;
   logic        rx_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   node_nic #(.NODEID(3), .TX_DEPTH(4), .RX_DEPTH(2)) dut (
      .clk                 (clk),
      .rst_b               (rst_b),
      .pkt_in              (pkt_in),
      .pkt_in_valid        (pkt_in_valid),
      .pkt_in_ready        (pkt_in_ready),
      .free_to_router      (free_to_router),
      .put_to_router       (put_to_router),
      .payload_to_router   (payload_to_router),
      .put_from_router     (put_from_router),
      .payload_from_router (payload_from_router),
      .free_from_node      (free_from_node),
      .pkt_out             (pkt_out),
      .pkt_out_valid       (pkt_out_valid),
      .pkt_out_ready       (pkt_out_ready),
      .misroute            (misroute),
      .rx_overflow         (rx_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // check byte k of packet p on the TX link, then advance one cycle
   task automatic tx_byte(input logic [31:0] p, input int k);
      logic [31:0] v;
      v = p >> (8 * (3 - k));
      chk("tx_put", 32'(put_to_router), 32'd1);
      chk("tx_byte", 32'(payload_to_router), 32'(v[7:0]));
      tick();
   endtask

   task automatic tx_expect(input logic [31:0] p);
      for (int k = 0; k < 4; k++) tx_byte(p, k);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      put_from_router     = 1'b1;
      payload_from_router = b;
      tick();
      put_from_router     = 1'b0;
      payload_from_router = 8'd0;
      repeat (gap) tick();
   endtask

   task automatic rx_pkt(input logic [31:0] p);
      logic [31:0] v;
      for (int k = 0; k < 4; k++) begin
         v = p >> (8 * (3 - k));
         send_byte(v[7:0], 0);
      end
   endtask

   task automatic pop();
      pkt_out_ready = 1'b1;
      tick();
      pkt_out_ready = 1'b0;
   endtask

   initial begin
      rst_b               = 1'b0;
      pkt_in              = 32'd0;
      pkt_in_valid        = 1'b0;
      free_to_router      = 1'b0;
      put_from_router     = 1'b0;
      payload_from_router = 8'd0;
      pkt_out_ready       = 1'b0;

      // ---- reset state ----
      #2;
      chk("rst_put", 32'(put_to_router), 32'd0);
      chk("rst_payload", 32'(payload_to_router), 32'd0);
      chk("rst_valid", 32'(pkt_out_valid), 32'd0);
      chk("rst_pkt_out", pkt_out, 32'd0);
      chk("rst_misroute", 32'(misroute), 32'd0);
      chk("rst_overflow", 32'(rx_overflow), 32'd0);
      chk("rst_in_ready", 32'(pkt_in_ready), 32'd1);
      chk("rst_free", 32'(free_from_node), 32'd1);
      tick();
      rst_b = 1'b1;
      tick();

      // ---- 1: single packet, write-to-first-byte latency 2 ----
      free_to_router = 1'b1;
      pkt_in = 32'h12A5B6C7; pkt_in_valid = 1'b1;
      tick();
      pkt_in_valid = 1'b0;
      chk("t1_put_early", 32'(put_to_router), 32'd0);
      tick();
      tx_expect(32'h12A5B6C7);
      chk("t1_put_end", 32'(put_to_router), 32'd0);
      chk("t1_payload_end", 32'(payload_to_router), 32'd0);

      // ---- 2a: three packets back to back ----
      pkt_in = 32'h11223344; pkt_in_valid = 1'b1;
      tick();
      pkt_in = 32'h55667788;
      tick();
      pkt_in = 32'h99AABBCC;
      tx_byte(32'h11223344, 0);
      pkt_in_valid = 1'b0;
      for (int k = 1; k < 4; k++) tx_byte(32'h11223344, k);
      tx_expect(32'h55667788);
      tx_expect(32'h99AABBCC);
      chk("t2_put_end", 32'(put_to_router), 32'd0);

      // ---- 2b: free drops after start, packet not split ----
      pkt_in = 32'hDEADBEEF; pkt_in_valid = 1'b1;
      tick();
      pkt_in = 32'hCAFE0123;
      tick();
      pkt_in_valid   = 1'b0;
      free_to_router = 1'b0;
      tx_expect(32'hDEADBEEF);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold", 32'(put_to_router), 32'd0);
         tick();
      end
      free_to_router = 1'b1;
      tick();
      tx_expect(32'hCAFE0123);
      chk("t2b_put_end", 32'(put_to_router), 32'd0);

      // ---- 2c: TX queue full ----
      free_to_router = 1'b0;
      pkt_in_valid   = 1'b1;
      pkt_in = 32'hA0000001; tick();
      pkt_in = 32'hA0000002; tick();
      pkt_in = 32'hA0000003; tick();
      pkt_in = 32'hA0000004; tick();
      chk("t2_full_ready", 32'(pkt_in_ready), 32'd0);
      pkt_in = 32'hBADBAD00; tick();
      pkt_in_valid = 1'b0;
      chk("t2_full_ready2", 32'(pkt_in_ready), 32'd0);
      free_to_router = 1'b1;
      tick();
      tx_expect(32'hA0000001);
      tx_expect(32'hA0000002);
      tx_expect(32'hA0000003);
      tx_expect(32'hA0000004);
      chk("t2c_put_end", 32'(put_to_router), 32'd0);
      chk("t2c_ready", 32'(pkt_in_ready), 32'd1);
      free_to_router = 1'b0;

      // ---- 3: RX with gaps ----
      send_byte(8'h03, 1);
      send_byte(8'h03, 3);
      send_byte(8'h00, 0);
      chk("t3_valid_early", 32'(pkt_out_valid), 32'd0);
      send_byte(8'h2A, 0);
      chk("t3_valid", 32'(pkt_out_valid), 32'd1);
      chk("t3_pkt", pkt_out, 32'h0303002A);
      chk("t3_misroute", 32'(misroute), 32'd0);
      pop();
      chk("t3_valid_pop", 32'(pkt_out_valid), 32'd0);
      chk("t3_pkt_pop", pkt_out, 32'd0);

      // ---- 4: RX queue full, overflow, push+pop while full ----
      rx_pkt(32'h13000001);
      chk("t4_free1", 32'(free_from_node), 32'd1);
      send_byte(8'h23, 0);
      chk("t4_free0", 32'(free_from_node), 32'd0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      rx_pkt(32'h33000003);
      chk("t4_overflow", 32'(rx_overflow), 32'd1);
      chk("t4_misroute", 32'(misroute), 32'd0);
      chk("t4_head_a", pkt_out, 32'h13000001);
      send_byte(8'h43, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      pkt_out_ready = 1'b1;
      send_byte(8'h04, 0);
      pkt_out_ready = 1'b0;
      chk("t4_head_b", pkt_out, 32'h23000002);
      pop();
      chk("t4_head_d", pkt_out, 32'h43000004);
      pop();
      chk("t4_empty", 32'(pkt_out_valid), 32'd0);
      chk("t4_free_end", 32'(free_from_node), 32'd1);

      // ---- 5: misroute sticky, packet delivered ----
      rx_pkt(32'h15000005);
      chk("t5_misroute", 32'(misroute), 32'd1);
      chk("t5_pkt", pkt_out, 32'h15000005);
      pop();
      repeat (3) tick();
      chk("t5_sticky", 32'(misroute), 32'd1);

      // ---- 6: reset mid-packet ----
      free_to_router = 1'b1;
      pkt_in = 32'hA1B2C3D4; pkt_in_valid = 1'b1;
      tick();
      pkt_in = 32'hE5F60718;
      tick();
      pkt_in_valid        = 1'b0;
      put_from_router     = 1'b1;
      payload_from_router = 8'hAA;
      tick();
      put_from_router     = 1'b0;
      payload_from_router = 8'h00;
      tick();
      chk("t6_byte2", 32'(payload_to_router), 32'h000000C3);
      #2 rst_b = 1'b0;
      #1;
      chk("t6_put_rst", 32'(put_to_router), 32'd0);
      chk("t6_payload_rst", 32'(payload_to_router), 32'd0);
      chk("t6_ready_rst", 32'(pkt_in_ready), 32'd1);
      chk("t6_free_rst", 32'(free_from_node), 32'd1);
      chk("t6_misroute_rst", 32'(misroute), 32'd0);
      chk("t6_overflow_rst", 32'(rx_overflow), 32'd0);
      #2 rst_b = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("t6_tx_empty", 32'(put_to_router), 32'd0);
         tick();
      end
      rx_pkt(32'h33123456);
      chk("t6_valid", 32'(pkt_out_valid), 32'd1);
      chk("t6_pkt", pkt_out, 32'h33123456);
      chk("t6_misroute", 32'(misroute), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
